// File: rtl/struct_lane_reader.sv
// struct_lane_reader
//   Read-side companion to the packed-struct lane writer. Captures a packed frame
//   {hdr, data[0:LANES-1], trl} in one cycle, then streams `count` lanes out over a
//   valid/ready port, starting at a dynamic lane index.
//
// Optional feature macro: STRUCT_LANE_READER_OOR_EN
//   defined   : oor_o port exists; out-of-range beats carry data_o = 0.
//   undefined : no oor_o port; out-of-range beats carry data_o = all-X.
//
// Ports
//   clk      : clock, all state on rising edge
//   rst      : asynchronous active-high reset
//   load_i   : capture frame/start/count (honoured only in idle)
//   frame_i  : packed frame, hdr in MSBs, trl in LSBs
//   start_i  : first lane index to emit
//   count_i  : number of lanes to emit (0 = capture only)
//   busy_o   : high while streaming
//   hdr_o    : captured hdr field
//   trl_o    : captured trl field
//   valid_o  : lane beat valid
//   ready_i  : consumer accepts beat
//   data_o   : lane data of current beat (0 when not valid)
//   idx_o    : index of current beat
//   last_o   : current beat is the final one of the burst
//   oor_o    : current beat index >= LANES (macro only)

module struct_lane_reader #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_i,
  input  logic [(LANES+2)*LANE_W-1:0]  frame_i,
  input  logic [IDX_W-1:0]             start_i,
  input  logic [IDX_W:0]               count_i,
  output logic                         busy_o,
  output logic [LANE_W-1:0]            hdr_o,
  output logic [LANE_W-1:0]            trl_o,
  output logic                         valid_o,
`ifdef STRUCT_LANE_READER_OOR_EN
  output logic                         oor_o,
`endif
  output logic [LANE_W-1:0]            data_o,
  output logic [IDX_W-1:0]             idx_o,
  output logic                         last_o,
  input  logic                         ready_i
);

  localparam int unsigned FrameW = (LANES + 2) * LANE_W;

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e              state_q, state_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W:0]      rem_q, rem_d;

  logic                accept;
  logic                rem_is_one;
  logic                in_range;
  logic [LANE_W-1:0]   lane_data;

  assign accept     = (state_q == StStream) & ready_i;
  assign rem_is_one = (rem_q == {{IDX_W{1'b0}}, 1'b1});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      frame_q <= frame_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (load_i && (count_i != '0)) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (accept && rem_is_one) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: the frame is only writable in idle, so it stays frozen mid-burst.
  always_comb begin
    frame_d = frame_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    if ((state_q == StIdle) && load_i) begin
      frame_d = frame_i;
      idx_d   = start_i;
      rem_d   = count_i;
    end else if (accept) begin
      // Index wraps modulo 2**IDX_W, deliberately not modulo LANES.
      idx_d = idx_q + IDX_W'(1);
      rem_d = rem_q - (IDX_W + 1)'(1);
    end
  end

  // Lane extraction: data[i] sits directly below hdr and ascends toward trl.
  always_comb begin
    lane_data = '0;
    in_range  = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        lane_data = frame_q[(LANES - i) * LANE_W +: LANE_W];
        in_range  = 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    busy_o  = (state_q == StStream);
    valid_o = (state_q == StStream);
    last_o  = valid_o & rem_is_one;
    idx_o   = idx_q;
    hdr_o   = frame_q[FrameW-1 -: LANE_W];
    trl_o   = frame_q[LANE_W-1:0];
    data_o  = '0;
    if (valid_o) begin
      if (in_range) begin
        data_o = lane_data;
      end else begin
`ifdef STRUCT_LANE_READER_OOR_EN
        data_o = '0;
`else
        data_o = {LANE_W{1'bx}};
`endif
      end
    end
`ifdef STRUCT_LANE_READER_OOR_EN
    oor_o = valid_o & ~in_range;
`endif
  end

endmodule
